// File: rtl/embedded_system_arb_pkg.sv
// Shared types and constants for the on-chip RAM two-master arbiter.
package embedded_system_arb_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FROZEN = 2'd2
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

endpackage

// File: rtl/embedded_system_arb_grant.sv
// Pure grant selection between the two masters.
// EMBEDDED_SYSTEM_ONCHIP_ARB_RR_EN selects round-robin; otherwise m0 has fixed priority.
module embedded_system_arb_grant
    import embedded_system_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_e last_grant,
    output logic [1:0] grant_onehot
);

`ifndef EMBEDDED_SYSTEM_ONCHIP_ARB_RR_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Contention policy: only the both-requesting case depends on the build.
    always_comb begin
        grant_onehot = 2'b00;
        case (req)
            2'b01:   grant_onehot = 2'b01;
            2'b10:   grant_onehot = 2'b10;
            2'b11: begin
`ifdef EMBEDDED_SYSTEM_ONCHIP_ARB_RR_EN
                if (last_grant == M1) begin
                    grant_onehot = 2'b01;
                end else begin
                    grant_onehot = 2'b10;
                end
`else
                grant_onehot = 2'b01;
`endif
            end
            default: grant_onehot = 2'b00;
        endcase
    end

endmodule

// File: rtl/embedded_system_onchip_memory2_0_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port on-chip RAM, with freeze/drain.
// EMBEDDED_SYSTEM_ONCHIP_ARB_RR_EN enables round-robin arbitration (default: m0 fixed priority).
module embedded_system_onchip_memory2_0_arbiter
    import embedded_system_arb_pkg::*;
#(
    parameter int DEPTH  = 64000,
    parameter int ADDR_W = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    output logic              frozen,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    arb_state_e        state_r, state_nxt_s;
    logic              run_s;
    logic [1:0]        req_s, grant_raw_s, grant_s;
    logic              accept_s, rd_accept_s, in_range_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [BE_W-1:0]   sel_be_s;
    logic              sel_read_s, sel_write_s;
    logic [DATA_W-1:0] sel_wdata_s, readdata_s;
    logic              rd_pending_r, rd_oor_r;
    master_id_e        rd_owner_r, last_grant_s;

    assign req_s = {m1_read | m1_write, m0_read | m0_write};

    embedded_system_arb_grant u_grant (
        .req          (req_s),
        .last_grant   (last_grant_s),
        .grant_onehot (grant_raw_s)
    );

    // State register; reset parks the arbiter in FROZEN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FROZEN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: a read accepted while freeze rises must drain its tag first.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (freeze) begin
                    state_nxt_s = rd_accept_s ? ST_DRAIN : ST_FROZEN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN:  state_nxt_s = ST_FROZEN;
            ST_FROZEN: state_nxt_s = freeze ? ST_FROZEN : ST_RUN;
            default:   state_nxt_s = ST_FROZEN;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        run_s  = (state_r == ST_RUN);
        frozen = (state_r == ST_FROZEN);
    end

    // Request mux: the granted master drives the RAM combinationally.
    always_comb begin
        if (grant_s[1]) begin
            sel_addr_s  = m1_address;
            sel_be_s    = m1_byteenable;
            sel_read_s  = m1_read;
            sel_write_s = m1_write;
            sel_wdata_s = m1_writedata;
        end else begin
            sel_addr_s  = m0_address;
            sel_be_s    = m0_byteenable;
            sel_read_s  = m0_read;
            sel_write_s = m0_write;
            sel_wdata_s = m0_writedata;
        end
    end

    assign grant_s        = run_s ? grant_raw_s : 2'b00;
    assign accept_s       = |grant_s;
    assign rd_accept_s    = accept_s & sel_read_s;
    assign in_range_s     = (32'(sel_addr_s) < DEPTH_U);
    assign m0_waitrequest = ~grant_s[0];
    assign m1_waitrequest = ~grant_s[1];

    // Out-of-range accesses are accepted but never reach the RAM.
    assign mem_chipselect = accept_s & in_range_s;
    assign mem_write      = mem_chipselect & sel_write_s;
    assign mem_address    = accept_s ? sel_addr_s : {ADDR_W{1'b0}};
    assign mem_byteenable = sel_write_s ? sel_be_s : {BE_W{1'b1}};
    assign mem_writedata  = sel_write_s ? sel_wdata_s : {DATA_W{1'b0}};

    // One-stage read tag: owner and range result travel alongside the RAM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending_r <= 1'b0;
            rd_owner_r   <= M0;
            rd_oor_r     <= 1'b0;
        end else begin
            rd_pending_r <= rd_accept_s;
            if (rd_accept_s) begin
                rd_owner_r <= grant_s[1] ? M1 : M0;
                rd_oor_r   <= ~in_range_s;
            end
        end
    end

`ifdef EMBEDDED_SYSTEM_ONCHIP_ARB_RR_EN
    master_id_e last_grant_r;

    // Remember who won the most recent accept for the round-robin policy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= M1;
        end else if (accept_s) begin
            last_grant_r <= grant_s[1] ? M1 : M0;
        end
    end
    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = M1;
`endif

    assign readdata_s       = (rd_pending_r && !rd_oor_r) ? mem_readdata : {DATA_W{1'b0}};
    assign m0_readdata      = readdata_s;
    assign m1_readdata      = readdata_s;
    assign m0_readdatavalid = rd_pending_r & (rd_owner_r == M0);
    assign m1_readdatavalid = rd_pending_r & (rd_owner_r == M1);

endmodule

// File: tb/tb_embedded_system_onchip_memory2_0_arbiter.sv
// Self-checking bench: behavioural RAM, directed scenarios and randomized traffic against a reference model.
module tb_embedded_system_onchip_memory2_0_arbiter;

    localparam int DEPTH = 64000;

    logic        clk = 1'b0;
    logic        reset, freeze, frozen;
    logic [15:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata, mem_readdata;

    embedded_system_onchip_memory2_0_arbiter dut (
        .clk(clk), .reset(reset), .freeze(freeze), .frozen(frozen),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [31:0] ram [0:65535];
    logic [31:0] ram_q = 32'h0;
    assign mem_readdata = ram_q;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    // Reference model state.
    logic [31:0] mdl_mem [0:65535];
    bit          m_frozen, m_drain, m_pv;
    int          m_last, m_po;
    logic [31:0] m_pd;

    bit          r_act [2];
    bit          r_wr  [2];
    logic [15:0] r_addr[2];
    logic [3:0]  r_be  [2];
    logic [31:0] r_data[2];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        m0_read = r_act[0] & !r_wr[0];  m0_write = r_act[0] & r_wr[0];
        m1_read = r_act[1] & !r_wr[1];  m1_write = r_act[1] & r_wr[1];
        m0_address = r_addr[0]; m0_byteenable = r_be[0]; m0_writedata = r_data[0];
        m1_address = r_addr[1]; m1_byteenable = r_be[1]; m1_writedata = r_data[1];
    endtask

    task automatic model_reset();
        m_frozen = 1'b1; m_drain = 1'b0; m_pv = 1'b0; m_last = 1; m_po = 0; m_pd = 32'h0;
        for (int i = 0; i < 2; i++) r_act[i] = 1'b0;
    endtask

    function automatic int pick_grant();
        if (m_frozen || m_drain) return -1;
        if (r_act[0] && r_act[1]) begin
`ifdef EMBEDDED_SYSTEM_ONCHIP_ARB_RR_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        if (r_act[0]) return 0;
        if (r_act[1]) return 1;
        return -1;
    endfunction

    // One cycle: compare DUT against the model, clock it, advance the model.
    task automatic step();
        int g;
        bit inr;
        drive();
        #1;
        g   = pick_grant();
        inr = (g >= 0) && (int'(r_addr[g]) < DEPTH);
        check("frozen", 32'(frozen), 32'(m_frozen));
        check("m0_waitrequest", 32'(m0_waitrequest), 32'(g != 0));
        check("m1_waitrequest", 32'(m1_waitrequest), 32'(g != 1));
        check("mem_chipselect", 32'(mem_chipselect), 32'(inr));
        if (inr) begin
            check("mem_write", 32'(mem_write), 32'(r_wr[g]));
            check("mem_address", 32'(mem_address), 32'(r_addr[g]));
            if (r_wr[g]) begin
                check("mem_writedata", mem_writedata, r_data[g]);
                check("mem_byteenable", 32'(mem_byteenable), 32'(r_be[g]));
            end
        end
        check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(m_pv && m_po == 0));
        check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(m_pv && m_po == 1));
        if (m_pv) begin
            check("m0_readdata", m0_readdata, m_pd);
            check("m1_readdata", m1_readdata, m_pd);
        end
        @(posedge clk);
        if (g >= 0) begin
            m_last = g;
            m_pv   = !r_wr[g];
            m_po   = g;
            m_pd   = inr ? mdl_mem[r_addr[g]] : 32'h0;
            if (r_wr[g] && inr)
                for (int b = 0; b < 4; b++)
                    if (r_be[g][b]) mdl_mem[r_addr[g]][b*8 +: 8] = r_data[g][b*8 +: 8];
            r_act[g] = 1'b0;
        end else begin
            m_pv = 1'b0;
        end
        if (m_frozen) begin
            m_frozen = freeze;
        end else if (m_drain) begin
            m_drain = 1'b0; m_frozen = 1'b1;
        end else if (freeze) begin
            if (g >= 0 && !r_wr[g]) m_drain = 1'b1;
            else m_frozen = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic req(input int m, input bit wr, input logic [15:0] a,
                       input logic [3:0] be, input logic [31:0] d);
        r_act[m] = 1'b1; r_wr[m] = wr; r_addr[m] = a; r_be[m] = be; r_data[m] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin ram[i] = 32'h0; mdl_mem[i] = 32'h0; end
        ram[16] = 32'hDEADBEEF; mdl_mem[16] = 32'hDEADBEEF;
        ram[32] = 32'h11111111; mdl_mem[32] = 32'h11111111;
        for (int i = 0; i < 2; i++) begin r_wr[i] = 1'b0; r_addr[i] = 16'h0; r_be[i] = 4'h0; r_data[i] = 32'h0; end
        model_reset();
        reset = 1'b1; freeze = 1'b0;
        drive();

        // Reset values
        @(negedge clk); #1;
        check("rst_frozen", 32'(frozen), 32'd1);
        check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        check("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        check("rst_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        check("rst_readdata", m0_readdata, 32'h0);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        reset = 1'b0;
        step();

        // m0 read of preloaded word
        req(0, 1'b0, 16'h0010, 4'hF, 32'h0); drive(); #1;
        check("lit_m0_wait_read", 32'(m0_waitrequest), 32'd0);
        step();
        check("lit_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        check("lit_m0_rdata", m0_readdata, 32'hDEADBEEF);
        check("lit_m1_rdv_idle", 32'(m1_readdatavalid), 32'd0);
        step();

        // m1 partial write then read back
        req(1, 1'b1, 16'h0020, 4'b0011, 32'hAABBCCDD); step();
        req(1, 1'b0, 16'h0020, 4'hF, 32'h0); step();
        check("lit_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        check("lit_m1_rdata_be", m1_readdata, 32'h1111CCDD);
        step();

        // Out-of-range write and read
        req(0, 1'b1, 16'hFA00, 4'hF, 32'h12345678); drive(); #1;
        check("lit_oor_cs", 32'(mem_chipselect), 32'd0);
        check("lit_oor_accept", 32'(m0_waitrequest), 32'd0);
        step();
        req(0, 1'b0, 16'hFA00, 4'hF, 32'h0); step();
        check("lit_oor_rdv", 32'(m0_readdatavalid), 32'd1);
        check("lit_oor_rdata", m0_readdata, 32'h0);
        step();

        // Freeze together with a read accept: drain, then frozen, then resume
        req(0, 1'b0, 16'h0010, 4'hF, 32'h0); freeze = 1'b1; step();
        check("lit_drain_frozen", 32'(frozen), 32'd0);
        check("lit_drain_rdv", 32'(m0_readdatavalid), 32'd1);
        req(1, 1'b0, 16'h0020, 4'hF, 32'h0); step();
        check("lit_frozen", 32'(frozen), 32'd1);
        check("lit_frozen_wait", 32'(m1_waitrequest), 32'd1);
        check("lit_frozen_cs", 32'(mem_chipselect), 32'd0);
        step();
        freeze = 1'b0; step();
        drive(); #1;
        check("lit_resume", 32'(frozen), 32'd0);
        check("lit_resume_wait", 32'(m1_waitrequest), 32'd0);
        step(); step();

        // Reset the cycle after a read accept
        req(0, 1'b0, 16'h0010, 4'hF, 32'h0); step();
        reset = 1'b1; #1;
        check("lit_rst_rdv", 32'(m0_readdatavalid), 32'd0);
        check("lit_rst_wait", 32'(m0_waitrequest), 32'd1);
        check("lit_rst_frozen", 32'(frozen), 32'd1);
        check("lit_rst_rdata", m0_readdata, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0; step();

        // Contention: both masters read continuously
        for (int k = 0; k < 8; k++) begin
            req(0, 1'b0, 16'h0010, 4'hF, 32'h0);
            req(1, 1'b0, 16'h0020, 4'hF, 32'h0);
            drive(); #1;
`ifdef EMBEDDED_SYSTEM_ONCHIP_ARB_RR_EN
            check("lit_rr_m0", 32'(m0_waitrequest), 32'(k % 2));
            check("lit_rr_m1", 32'(m1_waitrequest), 32'((k + 1) % 2));
`else
            check("lit_fix_m0", 32'(m0_waitrequest), 32'd0);
            check("lit_fix_m1", 32'(m1_waitrequest), 32'd1);
`endif
            step();
        end
        r_act[0] = 1'b0; r_act[1] = 1'b0; step();

        // Randomized traffic with freeze toggling
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!r_act[m] && $urandom_range(0, 2) == 0) begin
                    logic [15:0] a;
                    case ($urandom_range(0, 9))
                        7:       a = 16'd63999;
                        8:       a = 16'd64000;
                        9:       a = 16'hFA00;
                        default: a = 16'($urandom_range(16, 31));
                    endcase
                    req(m, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
                end
            end
            if ($urandom_range(0, 99) < 3) freeze = ~freeze;
            step();
        end
        freeze = 1'b0;
        for (int c = 0; c < 4; c++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
